// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder:
//     func3_e        load/store access size and extension encoding
//     word_depth()   number of storage words for a given byte-address width
//     WORD_DEPTH     word count for the default address width
//     func3_legal()  whether an encoding is allowed for a load or a store
//     func3_aligned() whether the low address bits suit the access size
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [2:0] {
      F3_BYTE   = 3'd0,   // LB / SB
      F3_HALF   = 3'd1,   // LH / SH
      F3_WORD   = 3'd2,   // LW / SW
      F3_BYTE_U = 3'd4,   // LBU (load only)
      F3_HALF_U = 3'd5    // LHU (load only)
   } func3_e;

   localparam int DM_ADDRESS_DEFAULT = 9;
   localparam int DATA_W_DEFAULT     = 32;

   // Storage is byte addressed but organised as words of four byte lanes.
   function automatic int word_depth(input int dm_address);
      return 1 << (dm_address - 2);
   endfunction

   localparam int WORD_DEPTH = word_depth(DM_ADDRESS_DEFAULT);

   // Unsigned variants only make sense on the load path.
   function automatic logic func3_legal(input logic [2:0] f3, input logic is_store);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_BYTE, F3_HALF, F3_WORD: ok = 1'b1;
         F3_BYTE_U, F3_HALF_U:      ok = !is_store;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
   function automatic logic func3_aligned(input logic [2:0] f3, input logic [1:0] lsb);
      logic ok;
      ok = 1'b1;
      case (f3)
         F3_HALF, F3_HALF_U: ok = (lsb[0] == 1'b0);
         F3_WORD:            ok = (lsb == 2'b00);
         default:            ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational load formatter: picks the byte or half-word lane out of a
//   stored word and sign- or zero-extends it to DATA_W bits.
//   Ports:
//     word    [DATA_W-1:0]  raw word read from storage
//     lane    [1:0]         low byte-address bits (byte lane / half select)
//     func3   [2:0]         access size and extension (func3_e encoding)
//     result  [DATA_W-1:0]  right-aligned, extended load value
// -----------------------------------------------------------------------------
module load_align
   import dmem_responder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        lane,
   input  logic [2:0]        func3,
   output logic [DATA_W-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (lane)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      // Half select ignores lane[0]; misaligned halves never reach here.
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      result = word;
      case (func3)
         F3_BYTE:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         F3_BYTE_U: result = {{(DATA_W-8){1'b0}}, byte_sel};
         F3_HALF:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
         F3_HALF_U: result = {{(DATA_W-16){1'b0}}, half_sel};
         default:   result = word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Byte-addressed, little-endian data memory with sub-word stores, sign/zero
//   extended loads, alignment checking and a saturating error counter.
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous active-high reset (memory contents retained)
//     MemRead    load request
//     MemWrite   store request (wins when both are high)
//     addr       byte address, taken modulo 2^DM_ADDRESS
//     wr_data    right-aligned store data
//     func3      access size / extension (func3_e encoding)
//     rd_data    registered load result
//     rd_valid   one-cycle pulse: rd_data updated by a completed load
//     misalign   one-cycle pulse: previous request was rejected
//     err_count  saturating count of rejected requests
//
//   Request/response protocol: there is no ready signal; a request present
//   on MemRead/MemWrite at a rising edge with reset low is always accepted
//   on that edge, so requests may be issued every cycle. Its outcome is
//   visible during the following cycle: a load pulses rd_valid with rd_data,
//   a rejection pulses misalign with rd_data forced to 0, a store pulses
//   nothing. A load issued the cycle after a store to the same word sees
//   the stored data.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DM_ADDRESS = DM_ADDRESS_DEFAULT,
   parameter int DATA_W     = DATA_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  misalign,
   output logic [7:0]            err_count
);

   localparam int WORDS = word_depth(DM_ADDRESS);
   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = DM_ADDRESS - 2;

   logic [DATA_W-1:0] mem [WORDS];

   logic [IDX_W-1:0]  word_idx;
   logic              is_store;
   logic              is_load;
   logic              reject;
   logic              do_store;
   logic              do_load;
   logic [LANES-1:0]  lane_en;
   logic [DATA_W-1:0] lane_data;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] load_value;

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   assign word_idx = addr[DM_ADDRESS-1:2];
   assign is_store = MemWrite;
   assign is_load  = MemRead && !MemWrite;

   assign reject   = (is_store || is_load) &&
                     (!func3_legal(func3, is_store) || !func3_aligned(func3, addr[1:0]));
   assign do_store = is_store && !reject;
   assign do_load  = is_load && !reject;

   // ---------------------------------------------------------------------
   // Store lane masking: replicate the right-aligned data across lanes and
   // enable only the lanes the access covers.
   // ---------------------------------------------------------------------
   always_comb begin
      lane_en   = '0;
      lane_data = '0;
      for (int i = 0; i < LANES; i++) begin
         case (func3)
            F3_BYTE: begin
               lane_data[i*8 +: 8] = wr_data[7:0];
               lane_en[i]          = (i == int'(addr[1:0]));
            end
            F3_HALF: begin
               lane_data[i*8 +: 8] = wr_data[(i % 2)*8 +: 8];
               lane_en[i]          = ((i / 2) == int'(addr[1]));
            end
            default: begin
               lane_data[i*8 +: 8] = wr_data[i*8 +: 8];
               lane_en[i]          = 1'b1;
            end
         endcase
      end
   end

   // Memory is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && do_store) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Load path: asynchronous array read, formatted, then registered. A
   // store at edge N is already in the array for a load at edge N+1.
   // ---------------------------------------------------------------------
   assign rd_word = mem[word_idx];

   load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .word   (rd_word),
      .lane   (addr[1:0]),
      .func3  (func3),
      .result (load_value)
   );

   // ---------------------------------------------------------------------
   // Response and status registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         misalign  <= 1'b0;
         err_count <= 8'd0;
      end else begin
         rd_valid <= 1'b0;
         misalign <= 1'b0;
         if (reject) begin
            rd_data  <= '0;
            misalign <= 1'b1;
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
         end else if (do_load) begin
            rd_data  <= load_value;
            rd_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A byte-array reference model
//   produces the expected response of every request; the expectation is
//   queued when the request is driven and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int AW = 9;
   localparam int DW = 32;

   // ---------------------------------------------------------------------
   // Clock / reset and DUT
   // ---------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          MemRead = 1'b0;
   logic          MemWrite = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [2:0]    func3 = 3'd0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          misalign;
   logic [7:0]    err_count;

   always #5 clk = ~clk;

   dmem_responder #(
      .DM_ADDRESS (AW),
      .DATA_W     (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .addr      (addr),
      .wr_data   (wr_data),
      .func3     (func3),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .misalign  (misalign),
      .err_count (err_count)
   );

   // ---------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------
   logic [7:0]  mem_m [0:(1<<AW)-1];
   logic [31:0] rd_data_m = '0;
   logic [7:0]  err_m = '0;
   // {misalign, rd_valid, err_count, rd_data}
   logic [41:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [2:0] f);
      logic [AW-1:0] hb;
      logic [AW-1:0] wb;
      logic [7:0]    b;
      logic [15:0]   h;
      logic [31:0]   w;
      hb = {a[AW-1:1], 1'b0};
      wb = {a[AW-1:2], 2'b00};
      b  = mem_m[a];
      h  = {mem_m[hb + 9'd1], mem_m[hb]};
      w  = {mem_m[wb + 9'd3], mem_m[wb + 9'd2], mem_m[wb + 9'd1], mem_m[wb]};
      case (f)
         3'd0:    return {{24{b[7]}}, b};
         3'd4:    return {24'd0, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd5:    return {16'd0, h};
         default: return w;
      endcase
   endfunction

   task automatic model_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] f);
      logic [AW-1:0] hb;
      logic [AW-1:0] wb;
      hb = {a[AW-1:1], 1'b0};
      wb = {a[AW-1:2], 2'b00};
      case (f)
         3'd0: mem_m[a] = d[7:0];
         3'd1: begin
            mem_m[hb]        = d[7:0];
            mem_m[hb + 9'd1] = d[15:8];
         end
         default: begin
            mem_m[wb]        = d[7:0];
            mem_m[wb + 9'd1] = d[15:8];
            mem_m[wb + 9'd2] = d[23:16];
            mem_m[wb + 9'd3] = d[31:24];
         end
      endcase
   endtask

   // ---------------------------------------------------------------------
   // Driver: one request per cycle, expectation queued at drive time and
   // compared #1 after the edge that accepted it.
   // ---------------------------------------------------------------------
   task automatic step(input logic rst, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [2:0] f, input string tag);
      logic        legal;
      logic        aligned;
      logic        exp_valid;
      logic        exp_mis;
      logic [41:0] e;
      @(negedge clk);
      reset    = rst;
      MemRead  = rd;
      MemWrite = wr;
      addr     = a;
      wr_data  = d;
      func3    = f;
      exp_valid = 1'b0;
      exp_mis   = 1'b0;
      if (rst) begin
         rd_data_m = '0;
         err_m     = '0;
      end else if (rd || wr) begin
         legal   = wr ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         aligned = (f == 3'd1 || f == 3'd5) ? (a[0] == 1'b0) :
                   (f == 3'd2)              ? (a[1:0] == 2'b00) : 1'b1;
         if (!legal || !aligned) begin
            rd_data_m = '0;
            exp_mis   = 1'b1;
            if (err_m != 8'hFF) err_m = err_m + 8'd1;
         end else if (wr) begin
            model_store(a, d, f);
         end else begin
            rd_data_m = model_load(a, f);
            exp_valid = 1'b1;
         end
      end
      exp_q.push_back({exp_mis, exp_valid, err_m, rd_data_m});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, " rd_data"},   rd_data,   e[31:0]);
      check({tag, " rd_valid"},  {31'd0, rd_valid},  {31'd0, e[40]});
      check({tag, " misalign"},  {31'd0, misalign},  {31'd0, e[41]});
      check({tag, " err_count"}, {24'd0, err_count}, {24'd0, e[39:32]});
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, tag);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      // Reset state
      step(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, "reset0");
      step(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, "reset1");

      // Fill the whole memory so every later load has a defined model value
      for (int w = 0; w < (1 << (AW-2)); w++) begin
         step(1'b0, 1'b0, 1'b1, AW'(w*4), $urandom, 3'd2, "init_sw");
      end

      // Word store then sub-word loads
      step(1'b0, 1'b0, 1'b1, 9'h010, 32'h8899AABB, 3'd2, "sw_010");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd2, "lw_010");
      step(1'b0, 1'b1, 1'b0, 9'h013, '0, 3'd0, "lb_013");
      step(1'b0, 1'b1, 1'b0, 9'h013, '0, 3'd4, "lbu_013");
      step(1'b0, 1'b1, 1'b0, 9'h012, '0, 3'd1, "lh_012");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd5, "lhu_010");
      idle("idle_hold");
      check("lw_010_direct", model_load(9'h010, 3'd2), 32'h8899AABB);

      // Byte store merge
      step(1'b0, 1'b0, 1'b1, 9'h011, 32'h00000055, 3'd0, "sb_011");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd2, "lw_merge");
      step(1'b0, 1'b0, 1'b1, 9'h016, 32'h0000C3D4, 3'd1, "sh_016");
      step(1'b0, 1'b1, 1'b0, 9'h014, '0, 3'd2, "lw_014");

      // Rejections
      step(1'b0, 1'b1, 1'b0, 9'h012, '0, 3'd2, "lw_mis_012");
      step(1'b0, 1'b0, 1'b1, 9'h013, 32'hFFFF, 3'd1, "sh_mis_013");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd2, "lw_after_sh_mis");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd3, "ld_f3_3");
      step(1'b0, 1'b0, 1'b1, 9'h010, 32'h1, 3'd6, "st_f3_6");
      step(1'b0, 1'b0, 1'b1, 9'h010, 32'h2, 3'd4, "st_f3_4");
      step(1'b0, 1'b1, 1'b0, 9'h011, '0, 3'd5, "lhu_mis_011");
      step(1'b0, 1'b1, 1'b0, 9'h010, '0, 3'd2, "lw_after_rej");

      // Both requests high: store only
      step(1'b0, 1'b1, 1'b1, 9'h020, 32'h12345678, 3'd2, "both_sw_020");
      step(1'b0, 1'b1, 1'b0, 9'h020, '0, 3'd2, "lw_020");

      // Requests during reset ignored; memory kept across reset
      step(1'b0, 1'b0, 1'b1, 9'h040, 32'hCAFEF00D, 3'd2, "sw_040");
      step(1'b1, 1'b0, 1'b1, 9'h040, 32'hDEADBEEF, 3'd2, "rst_sw_040");
      step(1'b0, 1'b1, 1'b0, 9'h040, '0, 3'd2, "lw_040");
      step(1'b0, 1'b1, 1'b0, 9'h012, '0, 3'd2, "lw_mis_pre");
      step(1'b0, 1'b1, 1'b0, 9'h020, '0, 3'd2, "lw_pre_rst");
      step(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, "rst_after_ld");
      step(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, "idle_post_rst");
      step(1'b0, 1'b1, 1'b0, 9'h020, '0, 3'd2, "lw_post_rst");

      // Top of address space
      step(1'b0, 1'b0, 1'b1, 9'h1FE, 32'h0000BEEF, 3'd1, "sh_1fe");
      step(1'b0, 1'b1, 1'b0, 9'h1FF, '0, 3'd0, "lb_1ff");

      // Random back-to-back traffic
      for (int n = 0; n < 300; n++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, (1 << AW) - 1)), $urandom,
              3'($urandom_range(0, 7)), "rand");
      end

      // Counter saturation
      step(1'b1, 1'b0, 1'b0, '0, '0, 3'd0, "reset_sat");
      for (int n = 0; n < 258; n++) begin
         step(1'b0, 1'b1, 1'b0, 9'h012, '0, 3'd2, "sat_err");
      end
      check("err_count_saturated", {24'd0, err_count}, 32'd255);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
